instr_fetch: RTL and testbench

Fetch stage directly upstream of the instruction BRAM. Holds the program counter, drives the BRAM read port (address, active-low read strobe, active-low write strobe held inactive), and presents each returned instruction word with its PC to decode over a valid/ready handshake. Supports branch redirect, a sticky halt, and back-pressure; it stalls by withholding the read strobe so the BRAM output register holds the pending word, with no local skid buffer.

---
 rtl/ifetch_pkg.sv | 14 +
 rtl/instr_fetch.sv | 98 +++++++++
 tb/tb_instr_fetch.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_pkg.sv
// Shared fetch-stage types and instruction-BRAM geometry (word address width, word width, boot address).
package ifetch_pkg;

  localparam int IMEM_ADDR_WIDTH = 10;
  localparam int IMEM_DATA_WIDTH = 32;
  localparam logic [IMEM_ADDR_WIDTH-1:0] DEFAULT_RESET_PC = '0;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } ifetch_state_e;

endpackage

// File: rtl/instr_fetch.sv
// Fetch stage: 1-cycle BRAM read latency, 1 instr/cycle; stalls by withholding imem_rd_n so the BRAM output register holds the word.
// Optional retired-fetch counter port fetch_count under IFETCH_PERF_EN.
module instr_fetch
  import ifetch_pkg::*;
#(
  parameter int ADDR_WIDTH = IMEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = IMEM_DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic                  imem_rd_n,
  output logic                  imem_wr_n,
  input  logic [DATA_WIDTH-1:0] imem_data_in,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  halt,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0] out_pc
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]           fetch_count
`endif
);

  ifetch_state_e         state_q;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] resp_pc_q, resp_pc_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  issue;
  logic                  handshake;
  logic                  redirect_take;

  always_comb begin
    issue         = (state_q == RUN) & ~halt & ~redirect_valid & (~resp_valid_q | out_ready);
    out_valid     = resp_valid_q & ~redirect_valid;
    handshake     = out_valid & out_ready;
    redirect_take = redirect_valid & (state_q != BOOT);

    imem_addr = pc_q;
    imem_rd_n = ~issue;
    imem_wr_n = 1'b1;
    out_instr = out_valid ? imem_data_in : '0;
    out_pc    = resp_pc_q;

    pc_d         = pc_q;
    resp_pc_d    = resp_pc_q;
    resp_valid_d = resp_valid_q;
    // Redirect squashes the word currently on the BRAM output and wins over halt/handshake.
    if (redirect_take) begin
      pc_d         = redirect_pc;
      resp_valid_d = 1'b0;
    end else if (issue) begin
      pc_d         = pc_q + ADDR_WIDTH'(1);
      resp_pc_d    = pc_q;
      resp_valid_d = 1'b1;
    end else if (handshake) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      resp_pc_q    <= RESET_PC;
      resp_valid_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      resp_pc_q    <= resp_pc_d;
      resp_valid_q <= resp_valid_d;
      case (state_q)
        BOOT:    state_q <= RUN;
        RUN:     if (halt && !redirect_valid) state_q <= HALTED;
        HALTED:  if (redirect_valid) state_q <= RUN;
        default: state_q <= BOOT;
      endcase
    end
  end

`ifdef IFETCH_PERF_EN
  logic [31:0] fetch_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count_q <= '0;
    end else if (handshake) begin
      fetch_count_q <= fetch_count_q + 32'd1;
    end
  end

  assign fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed phases push expected (pc, instr, cycle) into a scoreboard; a negedge monitor pops on each handshake.
module tb_instr_fetch;
  import ifetch_pkg::*;

  localparam int AW = 10;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          out_ready = 1'b0;
  logic          halt = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;

  logic [AW-1:0] addr_a, addr_b, opc_a, opc_b;
  logic          rd_n_a, rd_n_b, wr_n_a, wr_n_b, ov_a, ov_b;
  logic [DW-1:0] data_a = '0, data_b = '0, oi_a, oi_b;
  logic [31:0]   cnt_a, cnt_b;

  instr_fetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(10'h000)) dut_a (
    .clk(clk), .rst(rst), .imem_addr(addr_a), .imem_rd_n(rd_n_a), .imem_wr_n(wr_n_a),
    .imem_data_in(data_a), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt(halt), .out_valid(ov_a), .out_ready(out_ready), .out_instr(oi_a), .out_pc(opc_a)
`ifdef IFETCH_PERF_EN
    , .fetch_count(cnt_a)
`endif
  );

  instr_fetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(10'h3FE)) dut_b (
    .clk(clk), .rst(rst), .imem_addr(addr_b), .imem_rd_n(rd_n_b), .imem_wr_n(wr_n_b),
    .imem_data_in(data_b), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt(halt), .out_valid(ov_b), .out_ready(out_ready), .out_instr(oi_b), .out_pc(opc_b)
`ifdef IFETCH_PERF_EN
    , .fetch_count(cnt_b)
`endif
  );

`ifndef IFETCH_PERF_EN
  assign cnt_a = '0;
  assign cnt_b = '0;
`endif

  // BRAM model: word at address a holds 0xA0 + a; output register updates only on a read strobe.
  always @(posedge clk) if (!rd_n_a) data_a <= 32'hA0 + 32'(addr_a);
  always @(posedge clk) if (!rd_n_b) data_b <= 32'hA0 + 32'(addr_b);

  logic          sel_b = 1'b0;
  logic          m_valid, m_rd_n, m_wr_n;
  logic [AW-1:0] m_pc, m_addr;
  logic [DW-1:0] m_instr;
  logic [31:0]   m_cnt;
  always_comb begin
    m_valid = sel_b ? ov_b   : ov_a;
    m_rd_n  = sel_b ? rd_n_b : rd_n_a;
    m_wr_n  = sel_b ? wr_n_b : wr_n_a;
    m_pc    = sel_b ? opc_b  : opc_a;
    m_addr  = sel_b ? addr_b : addr_a;
    m_instr = sel_b ? oi_b   : oi_a;
    m_cnt   = sel_b ? cnt_b  : cnt_a;
  end

  int cyc = 0;
  int base = 0;
  int total = 0;
  int bad = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
    int            at;
  } exp_t;
  exp_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (rel cycle %0d)", name, act, exp, cyc - base);
    end
  endtask

  task automatic push(input logic [AW-1:0] pc, input logic [DW-1:0] instr, input int at);
    exp_t e;
    e.pc = pc; e.instr = instr; e.at = at;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst && m_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got pc 0x%0h instr 0x%0h want no handshake (rel cycle %0d)",
                 m_pc, m_instr, cyc - base);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_pc", 32'(m_pc), 32'(e.pc));
        check("sb_instr", m_instr, e.instr);
        check("sb_cycle", 32'(cyc - base), 32'(e.at));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int rel);
    while (cyc < base + rel) tick();
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic do_reset(input logic b);
    tick();
    sel_b = b;
    rst = 1'b1;
    out_ready = 1'b1;
    halt = 1'b0;
    redirect_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    base = cyc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    // Reset state and steady-state stream.
    do_reset(1'b0);
    neg();
    check("rst_rd_n", 32'(m_rd_n), 32'd1);
    check("rst_wr_n", 32'(m_wr_n), 32'd1);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_instr", m_instr, 32'd0);
    check("rst_pc", 32'(m_pc), 32'd0);
    check("rst_addr", 32'(m_addr), 32'd0);
    check("rst_cnt", m_cnt, 32'd0);
    push(10'd0, 32'hA0, 2);
    push(10'd1, 32'hA1, 3);
    push(10'd2, 32'hA2, 4);
    goto(1);
    neg();
    check("first_rd_n", 32'(m_rd_n), 32'd0);
    check("first_addr", 32'(m_addr), 32'd0);
    goto(4);
    neg();

    // Back-pressure on pc 1 for three cycles.
    do_reset(1'b0);
    push(10'd0, 32'hA0, 2);
    push(10'd1, 32'hA1, 6);
    push(10'd2, 32'hA2, 7);
    push(10'd3, 32'hA3, 8);
    for (int k = 3; k < 6; k++) begin
      goto(k);
      out_ready = 1'b0;
      neg();
      check("stall_rd_n", 32'(m_rd_n), 32'd1);
      check("stall_valid", 32'(m_valid), 32'd1);
      check("stall_instr", m_instr, 32'hA1);
      check("stall_pc", 32'(m_pc), 32'd1);
    end
    goto(6);
    out_ready = 1'b1;
    goto(8);
    neg();

    // Redirect while pc 5 is presented.
    do_reset(1'b0);
    for (int k = 0; k < 5; k++) push(AW'(k), 32'hA0 + 32'(k), k + 2);
    push(10'h40, 32'hE0, 9);
    push(10'h41, 32'hE1, 10);
    goto(7);
    redirect_valid = 1'b1;
    redirect_pc = 10'h40;
    neg();
    check("squash_valid", 32'(m_valid), 32'd0);
    check("squash_instr", m_instr, 32'd0);
    check("squash_rd_n", 32'(m_rd_n), 32'd1);
    goto(8);
    redirect_valid = 1'b0;
    neg();
    check("redir_rd_n", 32'(m_rd_n), 32'd0);
    check("redir_addr", 32'(m_addr), 32'h40);
    goto(10);
    neg();

    // Address wrap from RESET_PC 0x3FE.
    do_reset(1'b1);
    neg();
    check("wrap_rst_pc", 32'(m_pc), 32'h3FE);
    check("wrap_rst_addr", 32'(m_addr), 32'h3FE);
    push(10'h3FE, 32'h49E, 2);
    push(10'h3FF, 32'h49F, 3);
    push(10'h000, 32'hA0, 4);
    goto(4);
    neg();

    // Halt with a pending word, drain, then redirect to resume.
    do_reset(1'b0);
    push(10'd0, 32'hA0, 2);
    push(10'd1, 32'hA1, 6);
    push(10'h10, 32'hB0, 11);
    push(10'h11, 32'hB1, 12);
    for (int k = 3; k < 6; k++) begin
      goto(k);
      out_ready = 1'b0;
      halt = 1'b1;
      neg();
      check("halt_rd_n", 32'(m_rd_n), 32'd1);
      check("halt_valid", 32'(m_valid), 32'd1);
      check("halt_pc", 32'(m_pc), 32'd1);
    end
    goto(6);
    out_ready = 1'b1;
    neg();
    check("halt_drain_rd_n", 32'(m_rd_n), 32'd1);
    for (int k = 7; k < 9; k++) begin
      goto(k);
      neg();
      check("halted_valid", 32'(m_valid), 32'd0);
      check("halted_rd_n", 32'(m_rd_n), 32'd1);
    end
    goto(9);
    halt = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 10'h10;
    goto(10);
    redirect_valid = 1'b0;
    neg();
    check("resume_rd_n", 32'(m_rd_n), 32'd0);
    check("resume_addr", 32'(m_addr), 32'h10);
    goto(12);
    neg();

    // Seven handshakes with three stall cycles interleaved.
    do_reset(1'b0);
    push(10'd0, 32'hA0, 2);
    push(10'd1, 32'hA1, 3);
    push(10'd2, 32'hA2, 5);
    push(10'd3, 32'hA3, 6);
    push(10'd4, 32'hA4, 8);
    push(10'd5, 32'hA5, 10);
    push(10'd6, 32'hA6, 11);
    for (int k = 2; k < 12; k++) begin
      goto(k);
      out_ready = !(k == 4 || k == 7 || k == 9);
    end
    goto(12);
    out_ready = 1'b0;
    neg();
`ifdef IFETCH_PERF_EN
    check("perf_count", m_cnt, 32'd7);
`endif
    do_reset(1'b0);
    neg();
`ifdef IFETCH_PERF_EN
    check("perf_clear", m_cnt, 32'd0);
`endif
    check("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
